// File: rtl/ifu_if.sv
// Fetch-side bus bundle: stall vector, branch redirect, IF/ID payload and the
// instruction SRAM read port, seen from the fetch unit (master) or its peers (slave).
interface ifu_if;
  localparam int STALL_BUS   = 6;
  localparam int BR_WD       = 33;
  localparam int IF_TO_ID_WD = 33;

  logic [STALL_BUS-1:0]   stall;
  logic [BR_WD-1:0]       br_bus;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic                   inst_sram_en;
  logic [3:0]             inst_sram_wen;
  logic [31:0]            inst_sram_addr;
  logic [31:0]            inst_sram_wdata;
  logic [31:0]            inst_sram_rdata;
  logic [31:0]            id_inst;
  logic [31:0]            fetch_cnt;

  modport master (
    input  stall, br_bus, inst_sram_rdata,
    output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
           inst_sram_wdata, id_inst, fetch_cnt
  );

  modport slave (
    output stall, br_bus, inst_sram_rdata,
    input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
           inst_sram_wdata, id_inst, fetch_cnt
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, drives the instruction SRAM read port,
// applies branch redirects and keeps redirects/fetched words alive across stalls.
module ifu (
  input  logic clk,
  input  logic rst,
  ifu_if.master bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STALLED = 2'd2
  } state_t;

  localparam logic        STOP     = 1'b1;
  localparam logic        NO_STOP  = 1'b0;
  localparam logic [31:0] RESET_PC = 32'hbfbf_fffc;

  state_t      state;
  logic [31:0] pc;
  logic        ce;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic        hold_valid;
  logic [31:0] hold_inst;
  logic [31:0] fetch_cnt;

  logic        br_e;
  logic [31:0] br_addr;
  logic        pc_stall;
  logic        id_stall;
  logic        unused_stall;

  assign br_e         = bus.br_bus[32];
  assign br_addr      = bus.br_bus[31:0];
  assign pc_stall     = bus.stall[0];
  assign id_stall     = bus.stall[1];
  assign unused_stall = ^bus.stall[bus.STALL_BUS-1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ce         <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      hold_valid <= 1'b0;
      hold_inst  <= '0;
      fetch_cnt  <= '0;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (pc_stall == STOP) state <= STALLED;
        STALLED: if (pc_stall == NO_STOP) state <= RUN;
        default: state <= IDLE;
      endcase

      // A live branch outranks a redirect parked during an earlier stall.
      if (pc_stall == NO_STOP) begin
        if (br_e) begin
          pc <= br_addr;
        end else if (pend_valid) begin
          pc <= pend_addr;
        end else begin
          pc <= pc + 32'd4;
        end
        pend_valid <= 1'b0;
        ce         <= 1'b1;
        if (ce) begin
          fetch_cnt <= fetch_cnt + 32'd1;
        end
      end else if (br_e) begin
        pend_addr  <= br_addr;
        pend_valid <= 1'b1;
      end

      // Capture only the first stalled word; later SRAM data belongs to newer fetches.
      if (id_stall == STOP) begin
        if (!hold_valid) begin
          hold_inst  <= bus.inst_sram_rdata;
          hold_valid <= 1'b1;
        end
      end else begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign bus.if_to_id_bus    = {ce, pc};
  assign bus.inst_sram_en    = ce;
  assign bus.inst_sram_wen   = 4'b0;
  assign bus.inst_sram_addr  = pc;
  assign bus.inst_sram_wdata = '0;
  assign bus.id_inst         = hold_valid ? hold_inst : bus.inst_sram_rdata;
  assign bus.fetch_cnt       = fetch_cnt;
endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: directed scenarios then random stall/branch/reset
// traffic, checked against a behavioural fetch model.
module tb_ifu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ifu_if bus();

  ifu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic [31:0] cnt;
    logic [31:0] id;
    bit          has_gpc;
    logic [31:0] gpc;
    bit          has_gid;
    logic [31:0] gid;
  } exp_t;

  exp_t sb[$];

  // Behavioural model: the PC, whether fetching has started, the number of issued
  // fetches, redirects parked during a stall (newest wins) and the word latched
  // when decode first stalls.
  bit [31:0] m_pc;
  bit        m_ce;
  bit [31:0] m_cnt;
  bit [31:0] m_redir[$];
  bit [31:0] m_held[$];

  function automatic void model_reset();
    m_pc  = 32'hbfbf_fffc;
    m_ce  = 1'b0;
    m_cnt = 32'd0;
    m_redir.delete();
    m_held.delete();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit s0, input bit s1, input bit be,
                      input bit [31:0] ba, input bit [31:0] rd,
                      input bit hp, input bit [31:0] gp,
                      input bit hi, input bit [31:0] gi);
    exp_t e;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.stall           = {4'($urandom), s1, s0};
    bus.br_bus          = {be, ba};
    bus.inst_sram_rdata = rd;

    e.pc      = m_pc;
    e.ce      = m_ce;
    e.cnt     = m_cnt;
    e.id      = (m_held.size() != 0) ? m_held[0] : rd;
    e.has_gpc = hp;
    e.gpc     = gp;
    e.has_gid = hi;
    e.gid     = gi;
    sb.push_back(e);

    if (r) begin
      model_reset();
    end else begin
      if (!s0) begin
        if (m_ce) m_cnt = m_cnt + 32'd1;
        if (be)                    m_pc = ba;
        else if (m_redir.size()!=0) m_pc = m_redir[$];
        else                        m_pc = m_pc + 32'd4;
        m_redir.delete();
        m_ce = 1'b1;
      end else if (be) begin
        m_redir.push_back(ba);
      end
      if (s1) begin
        if (m_held.size() == 0) m_held.push_back(rd);
      end else begin
        m_held.delete();
      end
    end
  endtask

  // Shorthands: plain cycle, cycle with a golden PC, cycle with a golden id_inst.
  task automatic run(input bit s0, input bit s1, input bit be, input bit [31:0] ba);
    step(1'b0, s0, s1, be, ba, $urandom, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic run_pc(input bit s0, input bit be, input bit [31:0] ba, input bit [31:0] gp);
    step(1'b0, s0, 1'b0, be, ba, $urandom, 1'b1, gp, 1'b0, 32'd0);
  endtask

  task automatic run_id(input bit s1, input bit [31:0] rd, input bit [31:0] gi);
    step(1'b0, 1'b0, s1, 1'b0, 32'd0, rd, 1'b0, 32'd0, 1'b1, gi);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc",        bus.if_to_id_bus[31:0], e.pc);
        chk("ce",        {31'd0, bus.if_to_id_bus[32]}, {31'd0, e.ce});
        chk("sram_en",   {31'd0, bus.inst_sram_en}, {31'd0, e.ce});
        chk("sram_addr", bus.inst_sram_addr, e.pc);
        chk("sram_wen",  {28'd0, bus.inst_sram_wen}, 32'd0);
        chk("sram_wdata", bus.inst_sram_wdata, 32'd0);
        chk("fetch_cnt", bus.fetch_cnt, e.cnt);
        chk("id_inst",   bus.id_inst, e.id);
        if (e.has_gpc) chk("golden_pc", bus.inst_sram_addr, e.gpc);
        if (e.has_gid) chk("golden_id", bus.id_inst, e.gid);
      end
    end
  end

  initial begin : stimulus
    bus.stall           = '0;
    bus.br_bus          = '0;
    bus.inst_sram_rdata = '0;
    model_reset();

    // Reset release and sequential fetch, then an unstalled branch.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hbfbf_fffc, 1'b0, 32'd0);
    run_pc(1'b0, 1'b0, 32'd0, 32'hbfbf_fffc);
    run_pc(1'b0, 1'b0, 32'd0, 32'hbfc0_0000);
    run_pc(1'b0, 1'b0, 32'd0, 32'hbfc0_0004);
    run_pc(1'b0, 1'b1, 32'hbfc0_0100, 32'hbfc0_0008);
    run_pc(1'b0, 1'b0, 32'd0, 32'hbfc0_0100);
    run_pc(1'b0, 1'b0, 32'd0, 32'hbfc0_0104);

    // Three-cycle PC stall with a branch in its first cycle.
    run_pc(1'b1, 1'b1, 32'hbfc0_0200, 32'hbfc0_0108);
    run_pc(1'b1, 1'b0, 32'd0, 32'hbfc0_0108);
    run_pc(1'b1, 1'b0, 32'd0, 32'hbfc0_0108);
    run_pc(1'b0, 1'b0, 32'd0, 32'hbfc0_0108);
    run_pc(1'b0, 1'b0, 32'd0, 32'hbfc0_0200);

    // Four-cycle decode stall while the SRAM data changes underneath.
    run_id(1'b1, 32'h3c01_0001, 32'h3c01_0001);
    run_id(1'b1, 32'hdead_beef, 32'h3c01_0001);
    run_id(1'b1, 32'hdead_beef, 32'h3c01_0001);
    run_id(1'b1, 32'hdead_beef, 32'h3c01_0001);
    run_id(1'b0, 32'hdead_beef, 32'h3c01_0001);
    run_id(1'b0, 32'hdead_beef, 32'hdead_beef);

    // Two redirects in one stall, newest wins; then live branch on release.
    run(1'b1, 1'b0, 1'b1, 32'hbfc0_0300);
    run(1'b1, 1'b0, 1'b1, 32'hbfc0_0400);
    run(1'b0, 1'b0, 1'b0, 32'd0);
    run_pc(1'b0, 1'b0, 32'd0, 32'hbfc0_0400);
    run(1'b1, 1'b0, 1'b1, 32'hbfc0_0600);
    run(1'b0, 1'b0, 1'b1, 32'hbfc0_0500);
    run_pc(1'b0, 1'b0, 32'd0, 32'hbfc0_0500);
    run_pc(1'b0, 1'b1, 32'hffff_fffc, 32'hbfc0_0504);
    run_pc(1'b0, 1'b0, 32'd0, 32'hffff_fffc);
    run_pc(1'b0, 1'b0, 32'd0, 32'h0000_0000);

    // Reset in the middle of a stall with a parked redirect and a held word.
    run(1'b1, 1'b1, 1'b1, 32'hbfc0_0700);
    run(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'h1111_1111, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h2222_2222, 1'b1, 32'hbfbf_fffc, 1'b1, 32'h2222_2222);
    run_pc(1'b0, 1'b0, 32'd0, 32'hbfc0_0000);
    run_pc(1'b0, 1'b0, 32'd0, 32'hbfc0_0004);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 60) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
           ($urandom % 5) == 0, $urandom & 32'hffff_fffc, $urandom,
           1'b0, 32'd0, 1'b0, 32'd0);
    end

    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
